// File: rtl/mod_top.sv
// APB slave register bank: three RW registers and one RO status register
// that counts writes to read-only or unmapped addresses.
module mod_top #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   input  logic [ADDR_WIDTH-1:0] PADDR,
   input  logic                  PSELx,
   input  logic                  PENABLE,
   input  logic                  PWRITE,
   input  logic [DATA_WIDTH-1:0] PWDATA,
   output logic [DATA_WIDTH-1:0] PRDATA
);

   // Handshake: a transfer is a setup cycle (PSELx=1, PENABLE=0) followed by
   // PENABLE=1. Address/direction are captured in SETUP, the write commits
   // once in ACCESS, and HOLD absorbs any extra PENABLE-high cycles.
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

   state_t state;
   state_t state_next;

   logic [DATA_WIDTH-1:0] reg0;
   logic [DATA_WIDTH-1:0] reg1;
   logic [DATA_WIDTH-1:0] reg2;
   logic [15:0]           err_cnt;
   logic                  err_flag;
   logic [DATA_WIDTH-1:0] status_word;
   logic [DATA_WIDTH-1:0] rd_word;
   logic [ADDR_WIDTH-1:2] addr_q;
   logic                  write_q;
   logic                  rd_hit;
   logic                  wr_hit;
   logic                  commit;
   logic                  unused_addr_bits;

   assign unused_addr_bits = ^PADDR[1:0];

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            // PENABLE already high without a setup cycle is ignored here.
            if (PSELx && !PENABLE) state_next = SETUP;
         end
         SETUP: begin
            if (!PSELx)       state_next = IDLE;
            else if (PENABLE) state_next = ACCESS;
         end
         ACCESS: state_next = HOLD;
         HOLD: begin
            if (!PSELx)        state_next = IDLE;
            else if (!PENABLE) state_next = SETUP;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      status_word                 = '0;
      status_word[15:0]           = err_cnt;
      status_word[DATA_WIDTH-1]   = err_flag;
   end

   assign rd_hit = (PADDR[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]);
   assign wr_hit = (addr_q[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]);
   assign commit = (state == ACCESS) && write_q;

   always_comb begin
      rd_word = '0;
      if (rd_hit) begin
         case (PADDR[3:2])
            2'd0: rd_word = reg0;
            2'd1: rd_word = status_word;
            2'd2: rd_word = reg1;
            2'd3: rd_word = reg2;
            default: rd_word = '0;
         endcase
      end
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         reg0     <= '0;
         reg1     <= '0;
         reg2     <= '0;
         err_cnt  <= '0;
         err_flag <= 1'b0;
         PRDATA   <= '0;
         addr_q   <= '0;
         write_q  <= 1'b0;
      end else begin
         if ((state == SETUP) && PSELx) begin
            addr_q  <= PADDR[ADDR_WIDTH-1:2];
            write_q <= PWRITE;
            if (!PWRITE) PRDATA <= rd_word;
         end
         if (commit) begin
            if (wr_hit && (addr_q[3:2] != 2'd1)) begin
               case (addr_q[3:2])
                  2'd0:    reg0 <= PWDATA;
                  2'd2:    reg1 <= PWDATA;
                  2'd3:    reg2 <= PWDATA;
                  default: ;
               endcase
            end else begin
               // STATUS itself or an unmapped address: count and flag it.
               err_flag <= 1'b1;
               if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mod_top.sv
// Directed bench for the APB register bank: reset values, RW/RO/unmapped
// writes, long PENABLE holds, back-to-back transfers and mid-transfer reset.
module tb_mod_top;

   logic        PCLK;
   logic        PRESETn;
   logic [31:0] PADDR;
   logic        PSELx;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;

   int n_checks = 0;
   int n_pass   = 0;

   localparam logic [31:0] A_REG0   = 32'h8000_0000;
   localparam logic [31:0] A_STATUS = 32'h8000_0004;
   localparam logic [31:0] A_REG1   = 32'h8000_0008;
   localparam logic [31:0] A_REG2   = 32'h8000_000C;
   localparam logic [31:0] A_UNMAP  = 32'h8000_0010;

   mod_top dut (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .PADDR   (PADDR),
      .PSELx   (PSELx),
      .PENABLE (PENABLE),
      .PWRITE  (PWRITE),
      .PWDATA  (PWDATA),
      .PRDATA  (PRDATA)
   );

   // clock/reset block
   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   // Called just after an edge. en_cycles >= 2: SETUP->ACCESS, then commit.
   task automatic apb_write(input logic [31:0] addr, input logic [31:0] data,
                            input int en_cycles, input bit go_idle);
      PSELx   = 1'b1;
      PENABLE = 1'b0;
      PWRITE  = 1'b1;
      PADDR   = addr;
      PWDATA  = data;
      tick();
      PENABLE = 1'b1;
      repeat (en_cycles) tick();
      if (go_idle) begin
         PSELx   = 1'b0;
         PENABLE = 1'b0;
         tick();
      end
   endtask

   task automatic apb_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
      PSELx   = 1'b1;
      PENABLE = 1'b0;
      PWRITE  = 1'b0;
      PADDR   = addr;
      tick();
      PENABLE = 1'b1;
      tick();
      check_eq(tag, PRDATA, exp);
      tick();
      PSELx   = 1'b0;
      PENABLE = 1'b0;
      tick();
   endtask

   initial begin
      PRESETn = 1'b0;
      PSELx   = 1'b0;
      PENABLE = 1'b0;
      PWRITE  = 1'b0;
      PADDR   = '0;
      PWDATA  = '0;
      repeat (2) tick();
      check_eq("rst_prdata_in_reset", PRDATA, 32'h0);
      PRESETn = 1'b1;
      tick();
      check_eq("rst_prdata", PRDATA, 32'h0);
      apb_read(A_REG0,   32'h0, "rst_reg0");
      apb_read(A_STATUS, 32'h0, "rst_status");
      apb_read(A_REG1,   32'h0, "rst_reg1");
      apb_read(A_REG2,   32'h0, "rst_reg2");

      // valid write with a long PENABLE hold
      apb_write(A_REG0, 32'h1, 5, 1'b1);
      apb_read(A_REG0,   32'h0000_0001, "wr_reg0");
      apb_read(A_STATUS, 32'h0000_0000, "wr_status_clean");

      // write to RO status, held high ~4 cycles -> exactly one count
      apb_write(A_STATUS, 32'h90, 5, 1'b1);
      apb_read(A_STATUS, 32'h8000_0001, "ro_write_status");
      apb_read(A_REG0,   32'h0000_0001, "ro_write_reg0");

      // unmapped write and read
      apb_write(A_UNMAP, 32'hDEAD_BEEF, 2, 1'b1);
      apb_read(A_STATUS, 32'h8000_0002, "unmap_status");
      apb_read(A_UNMAP,  32'h0, "unmap_read");

      // back-to-back: HOLD -> SETUP without an idle cycle
      apb_write(A_REG1, 32'hA5A5_A5A5, 2, 1'b0);
      apb_write(A_REG2, 32'h5A5A_5A5A, 2, 1'b1);
      apb_read(A_REG1, 32'hA5A5_A5A5, "b2b_reg1");
      apb_read(A_REG2, 32'h5A5A_5A5A, "b2b_reg2");

      // PRDATA holds between transfers
      repeat (3) tick();
      check_eq("prdata_hold", PRDATA, 32'h5A5A_5A5A);

      // PENABLE high without a setup cycle: no access
      PSELx   = 1'b1;
      PENABLE = 1'b1;
      PWRITE  = 1'b1;
      PADDR   = A_REG0;
      PWDATA  = 32'hFFFF_FFFF;
      repeat (3) tick();
      PSELx   = 1'b0;
      PENABLE = 1'b0;
      tick();
      apb_read(A_REG0, 32'h0000_0001, "no_setup_reg0");

      // bus changes during HOLD are ignored
      apb_write(A_REG1, 32'h0000_0011, 2, 1'b0);
      PADDR  = A_REG2;
      PWDATA = 32'h0000_0022;
      repeat (2) tick();
      PSELx   = 1'b0;
      PENABLE = 1'b0;
      tick();
      apb_read(A_REG1, 32'h0000_0011, "hold_reg1");
      apb_read(A_REG2, 32'h5A5A_5A5A, "hold_reg2");

      // low address bits ignored
      apb_read(32'h8000_000B, 32'h0000_0011, "addr_lsb_ignored");

      // reset during the SETUP of a write to REG0
      PSELx   = 1'b1;
      PENABLE = 1'b0;
      PWRITE  = 1'b1;
      PADDR   = A_REG0;
      PWDATA  = 32'h0000_0077;
      tick();
      PENABLE = 1'b1;
      PRESETn = 1'b0;
      tick();
      PRESETn = 1'b1;
      tick();
      PSELx   = 1'b0;
      PENABLE = 1'b0;
      tick();
      apb_read(A_REG0,   32'h0, "midrst_reg0");
      apb_read(A_STATUS, 32'h0, "midrst_status");
      apb_read(A_REG1,   32'h0, "midrst_reg1");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
